// File: rtl/au_seq_pkg.sv
// Shared constants for the AU operand sequencer: one-hot state indices,
// LED phase codes, default timing values and a counter-width helper.
package au_seq_pkg;

  localparam int NUM_STATES = 7;

  localparam int S_WAIT_A = 0;
  localparam int S_LOAD_A = 1;
  localparam int S_WAIT_B = 2;
  localparam int S_LOAD_B = 3;
  localparam int S_SETTLE = 4;
  localparam int S_LOAD_O = 5;
  localparam int S_SHOW   = 6;

  localparam logic [NUM_STATES-1:0] ONEHOT_WAIT_A = 7'b000_0001;

  typedef enum logic [2:0] {
    PH_WAIT_A = 3'd0,
    PH_LOAD_A = 3'd1,
    PH_WAIT_B = 3'd2,
    PH_LOAD_B = 3'd3,
    PH_SETTLE = 3'd4,
    PH_LOAD_O = 3'd5,
    PH_SHOW   = 3'd6
  } phase_e;

  localparam int DEFAULT_SETTLE_CYCLES   = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  // Bits needed to hold values 0..max_count, never less than one.
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/enter_conditioner.sv
// Turns the raw enter button into a one-cycle enter_pulse: 2-flop synchronizer,
// optional debounce (macro AU_SEQ_DEBOUNCE_EN) and rising-edge detect.
module enter_conditioner
  import au_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic enter_raw,
  output logic enter_pulse
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       prev_q, prev_d;
  logic [1:0] armed_q, armed_d;
  logic       level;

`ifdef AU_SEQ_DEBOUNCE_EN
  localparam int DW = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          deb_q, deb_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;

  // Resetting high keeps a button held through reset from looking like a press.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (db_cnt_q == DB_LAST) begin
        deb_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      deb_q    <= 1'b1;
      db_cnt_q <= '0;
    end else begin
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level = deb_q;
`else
  assign level = sync2_q;
`endif

  // The reset zeros in the synchronizer are not real samples, so the edge
  // detector only starts tracking once they have been flushed out.
  always_comb begin
    sync1_d     = enter_raw;
    sync2_d     = sync1_q;
    armed_d     = {armed_q[0], 1'b1};
    prev_d      = armed_q[1] ? level : 1'b1;
    enter_pulse = level & ~prev_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b1;
      armed_q <= 2'b00;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/au_operand_sequencer.sv
// Sequences load strobes for the AU's A, B and result registers from one enter
// button; debounce is included when AU_SEQ_DEBOUNCE_EN is defined.
module au_operand_sequencer
  import au_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES   = DEFAULT_SETTLE_CYCLES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       enter,
  input  logic       opSelect,
  output logic       loadA,
  output logic       loadB,
  output logic       loadO,
  output logic       addSub,
  output logic       busy,
  output logic [2:0] phase
);

  localparam int SW = cnt_width(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

  logic                  enter_pulse;
  logic [NUM_STATES-1:0] state_q, state_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  add_sub_q, add_sub_d;

  enter_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_conditioner (
    .clk        (CLK),
    .rst        (CLR),
    .enter_raw  (enter),
    .enter_pulse(enter_pulse)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q   <= ONEHOT_WAIT_A;
      settle_q  <= '0;
      add_sub_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      add_sub_q <= add_sub_d;
    end
  end

  // Presses arriving outside the WAIT_A/WAIT_B/SHOW states are dropped.
  always_comb begin
    state_d   = '0;
    settle_d  = settle_q;
    add_sub_d = add_sub_q;
    if (state_q[S_WAIT_A]) begin
      if (enter_pulse) state_d[S_LOAD_A] = 1'b1;
      else             state_d[S_WAIT_A] = 1'b1;
    end else if (state_q[S_LOAD_A]) begin
      state_d[S_WAIT_B] = 1'b1;
    end else if (state_q[S_WAIT_B]) begin
      if (enter_pulse) begin
        state_d[S_LOAD_B] = 1'b1;
        add_sub_d         = opSelect;
      end else begin
        state_d[S_WAIT_B] = 1'b1;
      end
    end else if (state_q[S_LOAD_B]) begin
      state_d[S_SETTLE] = 1'b1;
      settle_d          = SETTLE_LOAD;
    end else if (state_q[S_SETTLE]) begin
      if (settle_q == '0) begin
        state_d[S_LOAD_O] = 1'b1;
      end else begin
        state_d[S_SETTLE] = 1'b1;
        settle_d          = settle_q - 1'b1;
      end
    end else if (state_q[S_LOAD_O]) begin
      state_d[S_SHOW] = 1'b1;
    end else if (state_q[S_SHOW]) begin
      if (enter_pulse) state_d[S_LOAD_A] = 1'b1;
      else             state_d[S_SHOW]   = 1'b1;
    end else begin
      state_d[S_WAIT_A] = 1'b1;
    end
  end

  always_comb begin
    loadA  = state_q[S_LOAD_A];
    loadB  = state_q[S_LOAD_B];
    loadO  = state_q[S_LOAD_O];
    busy   = state_q[S_LOAD_A] | state_q[S_LOAD_B] | state_q[S_SETTLE] | state_q[S_LOAD_O];
    addSub = add_sub_q;
    phase  = PH_WAIT_A;
    if      (state_q[S_LOAD_A]) phase = PH_LOAD_A;
    else if (state_q[S_WAIT_B]) phase = PH_WAIT_B;
    else if (state_q[S_LOAD_B]) phase = PH_LOAD_B;
    else if (state_q[S_SETTLE]) phase = PH_SETTLE;
    else if (state_q[S_LOAD_O]) phase = PH_LOAD_O;
    else if (state_q[S_SHOW])   phase = PH_SHOW;
  end

endmodule
